// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 receiver
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } ps2_state_t;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
   localparam int   DATA_W    = 8;

   // Number of system clock cycles in the inter-edge timeout window
   function automatic int timeout_cycles(input int clk_hz, input int timeout_us);
      return (clk_hz / 1000000) * timeout_us;
   endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// rtl/ps2_sync_filter.sv - 2-FF synchroniser plus run-length glitch filter for one PS/2 line
module ps2_sync_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic filt
);

   localparam int CW = $clog2(FILTER_LEN + 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] run_cnt;

   // Two-stage synchroniser; idle bus level is high, so reset to 1
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= pin;
         sync2 <= sync1;
      end
   end

   // Accept a new level only after FILTER_LEN consecutive samples disagree with the current one
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         filt    <= 1'b1;
         run_cnt <= '0;
      end else if (sync2 == filt) begin
         run_cnt <= '0;
      end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
         filt    <= sync2;
         run_cnt <= '0;
      end else begin
         run_cnt <= run_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 device-to-host frame receiver feeding a first-word-fall-through FIFO
module ps2_rx_fifo
   import ps2_pkg::*;
#(
   parameter int CLK_HZ     = 25000000,
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT_US = 2000,
   parameter int FIFO_DEPTH = 16
) (
   input  logic              clk_25mhz,
   input  logic              rst,
   input  logic              ps2_clk_i,
   input  logic              ps2_dat_i,
   input  logic              rd,
   output logic [DATA_W-1:0] data,
   output logic              rdy,
   output logic              overflow,
   output logic              parity_err,
   output logic              frame_err,
   output logic              busy
);

   localparam int TO_CYCLES = timeout_cycles(CLK_HZ, TIMEOUT_US);
   localparam int TW        = $clog2(TO_CYCLES + 1);
   localparam int AW        = $clog2(FIFO_DEPTH);
   localparam int CNTW      = AW + 1;

   logic              clk_f;
   logic              dat_f;
   logic              clk_prev;
   logic              fe;
   ps2_state_t        state;
   ps2_state_t        state_nxt;
   logic [DATA_W-1:0] shreg;
   logic [3:0]        bitcnt;
   logic              par_bit;
   logic [TW-1:0]     tcnt;
   logic              expire;
   logic              parity_ok;
   logic              push;
   logic              perr_c;
   logic              ferr_c;
   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wptr;
   logic [AW-1:0]     rptr;
   logic [CNTW-1:0]   count;
   logic              full;
   logic              do_pop;
   logic              do_push;

   ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
      .clk  (clk_25mhz),
      .rst  (rst),
      .pin  (ps2_clk_i),
      .filt (clk_f)
   );

   ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
      .clk  (clk_25mhz),
      .rst  (rst),
      .pin  (ps2_dat_i),
      .filt (dat_f)
   );

   // Previous filtered clock level for falling-edge detection
   always_ff @(posedge clk_25mhz or posedge rst) begin
      if (rst) clk_prev <= 1'b1;
      else     clk_prev <= clk_f;
   end

   assign fe     = clk_prev & ~clk_f;
   assign expire = (state != IDLE) && !fe && (tcnt == TW'(TO_CYCLES - 1));

   // FSM state register
   always_ff @(posedge clk_25mhz or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // FSM next state: one step per filtered clock falling edge, timeout aborts to IDLE
   always_comb begin
      state_nxt = state;
      if (expire) begin
         state_nxt = IDLE;
      end else if (fe) begin
         case (state)
            IDLE:    if (dat_f == START_BIT) state_nxt = DATA;
            DATA:    if (bitcnt == 4'(DATA_W - 1)) state_nxt = PARITY;
            PARITY:  state_nxt = STOP;
            STOP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // FSM outputs: frame verdict on the stop-bit edge, timeout error, busy flag
   always_comb begin
      parity_ok = ^{shreg, par_bit};
      push      = fe && (state == STOP) && parity_ok && (dat_f == STOP_BIT);
      perr_c    = fe && (state == STOP) && !parity_ok;
      ferr_c    = (fe && (state == STOP) && parity_ok && (dat_f != STOP_BIT)) || expire;
      busy      = (state != IDLE);
   end

   // Frame datapath: LSB-first shift register, bit counter and parity capture
   always_ff @(posedge clk_25mhz or posedge rst) begin
      if (rst) begin
         shreg   <= '0;
         bitcnt  <= '0;
         par_bit <= 1'b0;
      end else if (fe) begin
         case (state)
            IDLE:   bitcnt <= '0;
            DATA: begin
               shreg  <= {dat_f, shreg[DATA_W-1:1]};
               bitcnt <= bitcnt + 1'b1;
            end
            PARITY: par_bit <= dat_f;
            default: ;
         endcase
      end
   end

   // Inter-edge timer: cleared by each falling edge, counts only while a frame is in progress
   always_ff @(posedge clk_25mhz or posedge rst) begin
      if (rst)                        tcnt <= '0;
      else if (fe || (state == IDLE)) tcnt <= '0;
      else                            tcnt <= tcnt + 1'b1;
   end

   // Error outputs are registered so they line up with the rdy update for the same frame
   always_ff @(posedge clk_25mhz or posedge rst) begin
      if (rst) begin
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         parity_err <= perr_c;
         frame_err  <= ferr_c;
      end
   end

   // A pop on a full FIFO frees the slot the simultaneous push needs
   assign full    = (count == CNTW'(FIFO_DEPTH));
   assign do_pop  = rd && (count != '0);
   assign do_push = push && (!full || do_pop);

   // FIFO storage
   always_ff @(posedge clk_25mhz or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else if (do_push) begin
         mem[wptr] <= shreg;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth
   always_ff @(posedge clk_25mhz or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // Sticky overflow: set on a dropped good frame, cleared by a successful pop; set has priority
   always_ff @(posedge clk_25mhz or posedge rst) begin
      if (rst)                          overflow <= 1'b0;
      else if (push && full && !do_pop) overflow <= 1'b1;
      else if (do_pop)                  overflow <= 1'b0;
   end

   assign data = mem[rptr];
   assign rdy  = (count != '0);

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - directed self-checking bench for ps2_rx_fifo
module tb_ps2_rx_fifo;

   localparam int H      = 20;
   localparam int TO_CYC = 2500;

   logic       clk_25mhz = 1'b0;
   logic       rst       = 1'b1;
   logic       ps2_clk_i = 1'b1;
   logic       ps2_dat_i = 1'b1;
   logic       rd        = 1'b0;
   logic [7:0] data;
   logic       rdy;
   logic       overflow;
   logic       parity_err;
   logic       frame_err;
   logic       busy;

   int checks   = 0;
   int failures = 0;
   int perr_cnt = 0;
   int ferr_cnt = 0;

   ps2_rx_fifo #(
      .CLK_HZ     (25000000),
      .FILTER_LEN (8),
      .TIMEOUT_US (100),
      .FIFO_DEPTH (16)
   ) dut (
      .clk_25mhz  (clk_25mhz),
      .rst        (rst),
      .ps2_clk_i  (ps2_clk_i),
      .ps2_dat_i  (ps2_dat_i),
      .rd         (rd),
      .data       (data),
      .rdy        (rdy),
      .overflow   (overflow),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   always #20 clk_25mhz = ~clk_25mhz;

   always @(negedge clk_25mhz) begin
      if (parity_err) perr_cnt++;
      if (frame_err)  ferr_cnt++;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk_25mhz);
   endtask

   task automatic send_bit(input logic v, input int glitch);
      ps2_dat_i = v;
      if (glitch > 0) begin
         wait_cyc(5);
         ps2_clk_i = 1'b0;
         wait_cyc(glitch);
         ps2_clk_i = 1'b1;
         wait_cyc(H - 5 - glitch);
      end else begin
         wait_cyc(H);
      end
      ps2_clk_i = 1'b0;
      wait_cyc(H);
      ps2_clk_i = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par, input logic stop, input logic pop_at_stop);
      send_bit(1'b0, 0);
      for (int i = 0; i < 8; i++) send_bit(b[i], 0);
      send_bit(par, 0);
      ps2_dat_i = stop;
      wait_cyc(H);
      ps2_clk_i = 1'b0;
      if (pop_at_stop) begin
         wait_cyc(10);
         rd = 1'b1;
         wait_cyc(1);
         rd = 1'b0;
         wait_cyc(H - 11);
      end else begin
         wait_cyc(H);
      end
      ps2_clk_i = 1'b1;
      ps2_dat_i = 1'b1;
      wait_cyc(H);
   endtask

   task automatic do_pop();
      rd = 1'b1;
      wait_cyc(1);
      rd = 1'b0;
   endtask

   task automatic test_reset();
      logic [12:0] got;
      got = {data, rdy, overflow, parity_err, frame_err, busy};
      checks++;
      if (got !== 13'h0) begin
         failures++;
         $display("FAIL reset_outputs: got %0h expected 0", got);
      end
   endtask

   task automatic test_good_frame();
      int p0, f0, first;
      logic [7:0] b;
      p0 = perr_cnt; f0 = ferr_cnt; first = 0; b = 8'h1C;
      send_bit(1'b0, 0);
      for (int i = 0; i < 8; i++) send_bit(b[i], 0);
      send_bit(1'b0, 0);
      ps2_dat_i = 1'b1;
      wait_cyc(H);
      ps2_clk_i = 1'b0;
      for (int n = 1; n <= H; n++) begin
         wait_cyc(1);
         if (rdy && first == 0) first = n;
      end
      ps2_clk_i = 1'b1;
      wait_cyc(H);
      checks++;
      if (first !== 11) begin
         failures++;
         $display("FAIL good_latency: rdy rose %0d cycles after stop pin fall, expected 11", first);
      end
      checks++;
      if (data !== 8'h1C) begin
         failures++;
         $display("FAIL good_data: got %0h expected 1c", data);
      end
      checks++;
      if ((perr_cnt - p0) + (ferr_cnt - f0) !== 0) begin
         failures++;
         $display("FAIL good_no_err: got %0d error cycles expected 0", (perr_cnt - p0) + (ferr_cnt - f0));
      end
      do_pop();
      checks++;
      if (rdy !== 1'b0) begin
         failures++;
         $display("FAIL good_pop_rdy: got %0b expected 0", rdy);
      end
   endtask

   task automatic test_parity();
      int p0, f0;
      p0 = perr_cnt; f0 = ferr_cnt;
      send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (perr_cnt - p0 !== 1) begin
         failures++;
         $display("FAIL parity_pulse: got %0d high cycles expected 1", perr_cnt - p0);
      end
      checks++;
      if (rdy !== 1'b0 || ferr_cnt - f0 !== 0) begin
         failures++;
         $display("FAIL parity_drop: rdy=%0b frame_err cycles=%0d expected 0/0", rdy, ferr_cnt - f0);
      end
      send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
      checks++;
      if (rdy !== 1'b1 || data !== 8'hF0 || perr_cnt - p0 !== 1) begin
         failures++;
         $display("FAIL parity_good: rdy=%0b data=%0h perr=%0d expected 1/f0/1", rdy, data, perr_cnt - p0);
      end
      do_pop();
      f0 = ferr_cnt; p0 = perr_cnt;
      send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
      checks++;
      if (ferr_cnt - f0 !== 1 || perr_cnt - p0 !== 0 || rdy !== 1'b0) begin
         failures++;
         $display("FAIL stop_bit: ferr=%0d perr=%0d rdy=%0b expected 1/0/0", ferr_cnt - f0, perr_cnt - p0, rdy);
      end
   endtask

   task automatic test_glitch();
      int p0, f0, bad;
      logic [7:0] b;
      p0 = perr_cnt; f0 = ferr_cnt; bad = 0; b = 8'hA5;
      ps2_clk_i = 1'b0;
      wait_cyc(3);
      ps2_clk_i = 1'b1;
      for (int n = 0; n < 20; n++) begin
         wait_cyc(1);
         if (busy !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0 || rdy !== 1'b0 || ferr_cnt - f0 !== 0) begin
         failures++;
         $display("FAIL idle_glitch: busy cycles=%0d rdy=%0b ferr=%0d expected 0/0/0", bad, rdy, ferr_cnt - f0);
      end
      send_bit(1'b0, 0);
      for (int i = 0; i < 8; i++) send_bit(b[i], (i == 3) ? 5 : 0);
      send_bit(1'b1, 0);
      send_bit(1'b1, 0);
      ps2_dat_i = 1'b1;
      wait_cyc(H);
      checks++;
      if (rdy !== 1'b1 || data !== 8'hA5 || (perr_cnt - p0) + (ferr_cnt - f0) !== 0) begin
         failures++;
         $display("FAIL midbit_glitch: rdy=%0b data=%0h errs=%0d expected 1/a5/0", rdy, data, (perr_cnt - p0) + (ferr_cnt - f0));
      end
      do_pop();
   endtask

   task automatic test_timeout();
      int f0, n;
      f0 = ferr_cnt; n = 0;
      send_bit(1'b0, 0);
      for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
      ps2_dat_i = 1'b0;
      wait_cyc(H);
      ps2_clk_i = 1'b0;
      while (!frame_err && n < 4000) begin
         wait_cyc(1);
         n++;
         if (n == H) ps2_clk_i = 1'b1;
      end
      checks++;
      if (n !== 11 + TO_CYC) begin
         failures++;
         $display("FAIL timeout_latency: got %0d cycles expected %0d", n, 11 + TO_CYC);
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL timeout_busy: got %0b expected 0", busy);
      end
      ps2_dat_i = 1'b1;
      wait_cyc(H);
      checks++;
      if (ferr_cnt - f0 !== 1 || rdy !== 1'b0) begin
         failures++;
         $display("FAIL timeout_pulse: ferr=%0d rdy=%0b expected 1/0", ferr_cnt - f0, rdy);
      end
      send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
      checks++;
      if (rdy !== 1'b1 || data !== 8'h5A) begin
         failures++;
         $display("FAIL timeout_recover: rdy=%0b data=%0h expected 1/5a", rdy, data);
      end
      do_pop();
   endtask

   task automatic test_overflow();
      logic [7:0] b;
      for (int i = 0; i < 17; i++) begin
         b = 8'(i);
         send_frame(b, ~^b, 1'b1, 1'b0);
      end
      checks++;
      if (overflow !== 1'b1 || rdy !== 1'b1) begin
         failures++;
         $display("FAIL ovf_set: overflow=%0b rdy=%0b expected 1/1", overflow, rdy);
      end
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (rdy !== 1'b1 || data !== 8'(i)) begin
            failures++;
            $display("FAIL ovf_pop%0d: rdy=%0b data=%0h expected 1/%0h", i, rdy, data, i);
         end
         do_pop();
         if (i == 0) begin
            checks++;
            if (overflow !== 1'b0) begin
               failures++;
               $display("FAIL ovf_clear: got %0b expected 0", overflow);
            end
         end
      end
      checks++;
      if (rdy !== 1'b0) begin
         failures++;
         $display("FAIL ovf_empty: got %0b expected 0", rdy);
      end
      for (int i = 0; i < 16; i++) begin
         b = 8'(8'h20 + i);
         send_frame(b, ~^b, 1'b1, 1'b0);
      end
      b = 8'h30;
      send_frame(b, ~^b, 1'b1, 1'b1);
      checks++;
      if (overflow !== 1'b0) begin
         failures++;
         $display("FAIL full_poppush_ovf: got %0b expected 0", overflow);
      end
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (rdy !== 1'b1 || data !== 8'(8'h21 + i)) begin
            failures++;
            $display("FAIL full_pop%0d: rdy=%0b data=%0h expected 1/%0h", i, rdy, data, 8'h21 + i);
         end
         do_pop();
      end
      checks++;
      if (rdy !== 1'b0) begin
         failures++;
         $display("FAIL full_empty: got %0b expected 0", rdy);
      end
   endtask

   task automatic test_reset_mid();
      int p0, f0;
      logic [7:0] b;
      logic [12:0] got;
      send_frame(8'h33, 1'b1, 1'b1, 1'b0);
      b = 8'h03;
      send_bit(1'b0, 0);
      for (int i = 0; i < 8; i++) send_bit(b[i], 0);
      checks++;
      if (busy !== 1'b1 || rdy !== 1'b1) begin
         failures++;
         $display("FAIL mid_pre: busy=%0b rdy=%0b expected 1/1", busy, rdy);
      end
      rst = 1'b1;
      wait_cyc(2);
      got = {data, rdy, overflow, parity_err, frame_err, busy};
      checks++;
      if (got !== 13'h0) begin
         failures++;
         $display("FAIL mid_reset_outputs: got %0h expected 0", got);
      end
      rst = 1'b0;
      wait_cyc(1);
      p0 = perr_cnt; f0 = ferr_cnt;
      send_bit(1'b1, 0);
      send_bit(1'b1, 0);
      ps2_dat_i = 1'b1;
      wait_cyc(H);
      checks++;
      if (rdy !== 1'b0 || busy !== 1'b0 || (perr_cnt - p0) + (ferr_cnt - f0) !== 0) begin
         failures++;
         $display("FAIL mid_tail: rdy=%0b busy=%0b errs=%0d expected 0/0/0", rdy, busy, (perr_cnt - p0) + (ferr_cnt - f0));
      end
      send_frame(8'h7E, 1'b1, 1'b1, 1'b0);
      checks++;
      if (rdy !== 1'b1 || data !== 8'h7E) begin
         failures++;
         $display("FAIL mid_after: rdy=%0b data=%0h expected 1/7e", rdy, data);
      end
   endtask

   initial begin
      wait_cyc(3);
      test_reset();
      rst = 1'b0;
      wait_cyc(H);
      test_good_frame();
      test_parity();
      test_glitch();
      test_timeout();
      test_overflow();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
